score_digit_sequencer: RTL and testbench



---
 rtl/score_digit_sequencer.sv | 116 +++++++++++
 tb/tb_score_digit_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/score_digit_sequencer.sv
// score_digit_sequencer: converts a latched 8-bit score to BCD and plays its decimal digits on one 7-segment display.
module score_digit_sequencer #(
  parameter int DIGIT_CYCLES = 500000,
  parameter int GAP_CYCLES   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] score,
  input  logic       repeat_en,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] digit_idx
);
  typedef enum logic [1:0] {IDLE, CONVERT, SHOW, GAP} state_t;
  state_t      state_q, state_d;
  logic [19:0] sr_q, sr_d, dab;
  logic [23:0] cnt_q, cnt_d;
  logic [1:0]  pos_q, pos_d, idx_q, idx_d;
  logic [6:0]  seg_q, seg_d;
  logic        busy_q, busy_d, done_q, done_d, dp_q, dp_d;
  logic [3:0]  digit;
  function automatic logic [3:0] adj(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
  function automatic logic [1:0] first_of(input logic [11:0] b);
    return b[11:8] != 4'd0 ? 2'd2 : b[7:4] != 4'd0 ? 2'd1 : 2'd0;
  endfunction
  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction
  // Display outputs are registered from the current state, so they trail the FSM by one cycle.
  always_comb begin
    dab     = {adj(sr_q[19:16]), adj(sr_q[15:12]), adj(sr_q[11:8]), sr_q[7:0]} << 1;
    digit   = pos_q == 2'd2 ? sr_q[19:16] : pos_q == 2'd1 ? sr_q[15:12] : sr_q[11:8];
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q + 24'd1;
    pos_d   = pos_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = CONVERT;
          sr_d    = {12'd0, score};
        end
      end
      CONVERT: begin
        sr_d = dab;
        if (cnt_q == 24'd7) begin
          state_d = SHOW;
          pos_d   = first_of(dab[19:8]);
          cnt_d   = '0;
        end
      end
      SHOW: if (cnt_q == 24'(DIGIT_CYCLES - 1)) begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: if (cnt_q == 24'(GAP_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = pos_q != 2'd0 || repeat_en ? SHOW : IDLE;
        pos_d   = pos_q != 2'd0 ? pos_q - 2'd1 : first_of(sr_q[19:8]);
        done_d  = pos_q == 2'd0 && !repeat_en;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    seg_d  = state_q == SHOW ? glyph(digit) : 7'h7F;
    idx_d  = state_q == SHOW ? pos_q : 2'd3;
    dp_d   = !(state_q == SHOW && pos_q == 2'd0);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      idx_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      idx_q   <= idx_d;
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;
endmodule

// File: tb/tb_score_digit_sequencer.sv
// tb_score_digit_sequencer: checks score_digit_sequencer against a timeline model of the digit playback.
module tb_score_digit_sequencer;
  localparam int D = 4;
  localparam int G = 2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] score = 8'd0;
  logic       repeat_en = 1'b0;
  logic       busy, done, dp;
  logic [6:0] seg;
  logic [1:0] digit_idx;
  score_digit_sequencer #(.DIGIT_CYCLES(D), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .start(start), .score(score), .repeat_en(repeat_en),
    .busy(busy), .done(done), .seg(seg), .dp(dp), .digit_idx(digit_idx)
  );
  always #5 clk = ~clk;
  typedef struct {int k; logic [11:0] m; logic [11:0] v;} pin_t;
  pin_t        pins[$];
  int          cyc = 0, base = 0, kk = 0, checks = 0, fails = 0;
  int          m_score = 0, m_passes = 1;
  bit          active = 1'b0;
  logic [11:0] exp_v, got_v;
  logic [6:0]  gl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  always @(posedge clk) cyc <= cyc + 1;
  // Expected {busy,done,digit_idx,dp,seg} k edges after the edge that accepted start.
  function automatic logic [11:0] model(int k);
    int h, t, u, n, total, j, slot, p;
    int dv[3];
    h = m_score / 100;
    t = (m_score / 10) % 10;
    u = m_score % 10;
    if (h != 0) begin n = 3; dv[0] = h; dv[1] = t; dv[2] = u; end
    else if (t != 0) begin n = 2; dv[0] = t; dv[1] = u; dv[2] = 0; end
    else begin n = 1; dv[0] = u; dv[1] = 0; dv[2] = 0; end
    total = 8 + m_passes * n * (D + G);
    if (!active || k < 0 || k > total) return {1'b0, 1'b0, 2'd3, 1'b1, 7'h7F};
    if (k == total) return {1'b0, 1'b1, 2'd3, 1'b1, 7'h7F};
    if (k < 9) return {1'b1, 1'b0, 2'd3, 1'b1, 7'h7F};
    j    = k - 9;
    slot = (j / (D + G)) % n;
    if (j % (D + G) >= D) return {1'b1, 1'b0, 2'd3, 1'b1, 7'h7F};
    p = n - 1 - slot;
    return {1'b1, 1'b0, 2'(p), p != 0, gl[dv[slot]]};
  endfunction
  always @(negedge clk or posedge rst) begin
    #1;
    kk    = cyc - base;
    exp_v = model(kk);
    got_v = {busy, done, digit_idx, dp, seg};
    checks++;
    if (got_v !== exp_v) begin
      fails++;
      $display("FAIL model k=%0d score=%0d got=%b want=%b", kk, m_score, got_v, exp_v);
    end
    if (active) foreach (pins[i]) if (pins[i].k == kk) begin
      checks++;
      if ((got_v & pins[i].m) !== pins[i].v) begin
        fails++;
        $display("FAIL pin k=%0d score=%0d got=%b want=%b mask=%b", kk, m_score, got_v & pins[i].m, pins[i].v, pins[i].m);
      end
    end
  end
  task automatic pin(int k, logic [11:0] m, logic [11:0] v);
    pins.push_back('{k, m, v});
  endtask
  task automatic wait_k(int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cyc - base != k && n < 500);
    if (n >= 500) begin
      $display("FAIL wait_k k=%0d never reached", k);
      $fatal(1);
    end
  endtask
  task automatic go(int s, int p, bit rep);
    #2;
    pins.delete();
    m_score   = s;
    m_passes  = p;
    base      = cyc + 1;
    active    = 1'b1;
    score     = 8'(s);
    start     = 1'b1;
    repeat_en = rep;
    @(posedge clk);
    #2 start = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    go(255, 1, 0);
    pin(9, 12'h37F, 12'b00_10_0_0100100);
    pin(15, 12'h37F, 12'b00_01_0_0010010);
    pin(21, 12'h3FF, 12'b00_00_0_0010010);
    pin(25, 12'h400, 12'h000);
    pin(26, 12'h400, 12'h400);
    wait_k(26);
    go(100, 1, 0);
    pin(15, 12'h37F, 12'b00_01_0_1000000);
    pin(21, 12'h3FF, 12'b00_00_0_1000000);
    wait_k(26);
    go(7, 1, 0);
    pin(9, 12'h3FF, 12'b00_00_0_1111000);
    pin(14, 12'hC00, 12'h400);
    wait_k(14);
    go(0, 1, 0);
    pin(9, 12'h3FF, 12'b00_00_0_1000000);
    wait_k(14);
    go(10, 1, 0);
    pin(15, 12'h3FF, 12'b00_00_0_1000000);
    pin(20, 12'h400, 12'h400);
    wait_k(20);
    go(58, 1, 0);
    pin(15, 12'h3FF, 12'b00_00_0_0000000);
    wait_k(12);
    #2 score = 8'd99;
    start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_k(20);
    go(31, 1, 0);
    pin(9, 12'h37F, 12'b00_01_0_0110000);
    wait_k(20);
    go(42, 3, 1);
    pin(9, 12'h37F, 12'b00_01_0_0011001);
    pin(21, 12'h37F, 12'b00_01_0_0011001);
    pin(27, 12'h3FF, 12'b00_00_0_0100100);
    pin(32, 12'h400, 12'h000);
    pin(44, 12'h400, 12'h400);
    wait_k(35);
    #2 repeat_en = 1'b0;
    wait_k(46);
    go(123, 1, 0);
    wait_k(16);
    #2 active = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    go(9, 1, 0);
    pin(9, 12'h3FF, 12'b00_00_0_0010000);
    pin(14, 12'hC00, 12'h400);
    wait_k(17);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
